// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the pipelined MIPS core.
// Compares ID source registers against EX/MEM destinations, produces
// registered per-operand forwarding selects for the EX stage, raises a
// one-cycle stall plus EX bubble on load-use, and keeps saturating
// performance counters for stalls and forwarding cycles.
module fwd_hazard_unit #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [NUM_SRC*AW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]     id_src_used,
  input  logic                   ex_valid,
  input  logic [AW-1:0]          ex_rd,
  input  logic                   ex_regwrite,
  input  logic                   ex_memread,
  input  logic [AW-1:0]          mem_rd,
  input  logic                   mem_regwrite,
  input  logic                   cnt_clr,
  output logic                   stall,
  output logic                   flush_ex,
  output logic [2*NUM_SRC-1:0]   fwd_sel,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       fwd_cnt
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b10;
  localparam logic [1:0] SEL_MEM = 2'b01;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Per-operand select encoding; EX/MEM result wins over MEM/WB because it
  // is the younger producer of the same register.
  function automatic logic [1:0] sel_enc(input logic live,
                                         input logic ex_hit,
                                         input logic mem_hit,
                                         input logic stall_now);
    logic [1:0] sel;
    sel = SEL_RF;
    if (stall_now || !live) sel = SEL_RF;
    else if (ex_hit)        sel = SEL_EX;
    else if (mem_hit)       sel = SEL_MEM;
    return sel;
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_stall_fsm;
  logic                 w_stall;
  logic                 w_hazard;
  logic [AW-1:0]        w_src      [NUM_SRC];
  logic [NUM_SRC-1:0]   w_live;
  logic [NUM_SRC-1:0]   w_ex_hit;
  logic [NUM_SRC-1:0]   w_mem_hit;
  logic [NUM_SRC-1:0]   w_load_use;
  logic [2*NUM_SRC-1:0] w_fwd_nxt;
  logic                 w_fwd_any;
  logic [2*NUM_SRC-1:0] r_fwd_sel_p1;
  logic [CNT_W-1:0]     r_stall_cnt;
  logic [CNT_W-1:0]     r_fwd_cnt;

  // Register $0 is hard-wired to zero, so it never creates a dependency on
  // either side of the comparison.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_op
    assign w_src[g]      = id_src[g*AW +: AW];
    assign w_live[g]     = id_valid & id_src_used[g] & (w_src[g] != '0);
    assign w_ex_hit[g]   = ex_valid & ex_regwrite & (ex_rd != '0) &
                           (ex_rd == w_src[g]);
    assign w_mem_hit[g]  = mem_regwrite & (mem_rd != '0) & (mem_rd == w_src[g]);
    assign w_load_use[g] = w_live[g] & w_ex_hit[g] & ex_memread;
    assign w_fwd_nxt[2*g +: 2] = sel_enc(w_live[g], w_ex_hit[g], w_mem_hit[g],
                                         w_stall);
  end

  assign w_hazard  = |w_load_use;
  assign w_fwd_any = |w_fwd_nxt;

  // Stall is suppressed while reset is asserted so the pipeline is not held.
  assign w_stall   = w_stall_fsm & rst_n;
  assign stall     = w_stall;
  assign flush_ex  = w_stall;
  assign fwd_sel   = r_fwd_sel_p1;
  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;

  // FSM state register; BUBBLE lasts exactly one cycle after a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state and stall decode; BUBBLE blocks back-to-back stalls.
  always_comb begin
    w_state_nxt = r_state;
    w_stall_fsm = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_stall_fsm = w_hazard;
        if (w_hazard) w_state_nxt = ST_BUBBLE;
      end
      ST_BUBBLE: begin
        w_stall_fsm = 1'b0;
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_stall_fsm = 1'b0;
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // ID -> EX boundary: selects computed in ID are held for the EX cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) r_fwd_sel_p1 <= '0;
    else        r_fwd_sel_p1 <= w_fwd_nxt;
  end

  // Performance counters; clear beats increment, both saturate.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall)   r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_fwd_any) r_fwd_cnt   <= sat_inc(r_fwd_cnt);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit. A second instance with
// NUM_SRC=1 and CNT_W=2 shares operand 0 and exercises counter saturation.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic        cnt_clr;

  logic        stall, flush_ex;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_cnt, fwd_cnt;

  logic        stall2, flush_ex2;
  logic [1:0]  fwd_sel2;
  logic [1:0]  stall_cnt2, fwd_cnt2;

  int n_tests;
  int n_fail;

  fwd_hazard_unit #(.AW(5), .NUM_SRC(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .cnt_clr(cnt_clr), .stall(stall),
    .flush_ex(flush_ex), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt),
    .fwd_cnt(fwd_cnt)
  );

  fwd_hazard_unit #(.AW(5), .NUM_SRC(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src[4:0]),
    .id_src_used(id_src_used[0]), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .cnt_clr(cnt_clr), .stall(stall2),
    .flush_ex(flush_ex2), .fwd_sel(fwd_sel2), .stall_cnt(stall_cnt2),
    .fwd_cnt(fwd_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [1:0] used);
    id_valid    = v;
    id_src      = {rt, rs};
    id_src_used = used;
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic mr,
                        input logic [4:0] rd);
    ex_valid    = v;
    ex_regwrite = rw;
    ex_memread  = mr;
    ex_rd       = rd;
  endtask

  task automatic set_mem(input logic rw, input logic [4:0] rd);
    mem_regwrite = rw;
    mem_rd       = rd;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cnt_clr = 1'b0;
    rst_n   = 1'b0;
    // Hazard present during reset: stall must stay low.
    set_id(1'b1, 5'd8, 5'd0, 2'b01);
    set_ex(1'b1, 1'b1, 1'b1, 5'd8);
    set_mem(1'b0, 5'd0);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_flush", flush_ex, 1'b0);
    step();
    chk("rst_fwd_sel", fwd_sel, 4'b0000);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_fwd_cnt", fwd_cnt, 16'd0);
    chk("rst_fwd_sel2", fwd_sel2, 2'b00);

    // EX-to-EX forward on rs.
    rst_n = 1'b1;
    set_id(1'b1, 5'd5, 5'd9, 2'b11);
    set_ex(1'b1, 1'b1, 1'b0, 5'd5);
    set_mem(1'b0, 5'd0);
    #1;
    chk("exfwd_stall", stall, 1'b0);
    step();
    chk("exfwd_sel", fwd_sel, 4'b0010);
    chk("exfwd_cnt", fwd_cnt, 16'd1);
    chk("exfwd_sel2", fwd_sel2, 2'b10);

    // EX beats MEM when both match.
    set_id(1'b1, 5'd6, 5'd6, 2'b11);
    set_ex(1'b1, 1'b1, 1'b0, 5'd6);
    set_mem(1'b1, 5'd6);
    step();
    chk("prio_ex_sel", fwd_sel, 4'b1010);
    chk("prio_ex_cnt", fwd_cnt, 16'd2);
    ex_regwrite = 1'b0;
    step();
    chk("prio_mem_sel", fwd_sel, 4'b0101);
    chk("prio_mem_cnt", fwd_cnt, 16'd3);

    // Load-use: one stall, then MEM/WB forward.
    set_id(1'b1, 5'd8, 5'd9, 2'b11);
    set_ex(1'b1, 1'b1, 1'b1, 5'd8);
    set_mem(1'b0, 5'd0);
    #1;
    chk("lu_stall", stall, 1'b1);
    chk("lu_flush", flush_ex, 1'b1);
    chk("lu_stall2", stall2, 1'b1);
    step();
    chk("lu_sel", fwd_sel, 4'b0000);
    chk("lu_stall_cnt", stall_cnt, 16'd1);
    chk("lu_fwd_cnt", fwd_cnt, 16'd3);
    set_ex(1'b0, 1'b0, 1'b0, 5'd0);
    set_mem(1'b1, 5'd8);
    #1;
    chk("lu2_stall", stall, 1'b0);
    step();
    chk("lu2_sel", fwd_sel, 4'b0001);
    chk("lu2_stall_cnt", stall_cnt, 16'd1);
    chk("lu2_fwd_cnt", fwd_cnt, 16'd4);
    chk("lu2_fwd_cnt2_sat", fwd_cnt2, 2'd3);

    // $0, unused operands, invalid ID.
    set_id(1'b1, 5'd0, 5'd0, 2'b11);
    set_ex(1'b1, 1'b1, 1'b1, 5'd0);
    set_mem(1'b1, 5'd0);
    #1;
    chk("zero_stall", stall, 1'b0);
    step();
    chk("zero_sel", fwd_sel, 4'b0000);
    set_id(1'b1, 5'd7, 5'd7, 2'b00);
    set_ex(1'b1, 1'b1, 1'b1, 5'd7);
    set_mem(1'b1, 5'd7);
    #1;
    chk("unused_stall", stall, 1'b0);
    step();
    chk("unused_sel", fwd_sel, 4'b0000);
    set_id(1'b0, 5'd7, 5'd7, 2'b11);
    #1;
    chk("novalid_stall", stall, 1'b0);
    step();
    chk("novalid_sel", fwd_sel, 4'b0000);
    chk("novalid_fwd_cnt", fwd_cnt, 16'd4);

    // Clear counters on an idle cycle.
    set_id(1'b0, 5'd0, 5'd0, 2'b00);
    set_ex(1'b0, 1'b0, 1'b0, 5'd0);
    set_mem(1'b0, 5'd0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_stall_cnt", stall_cnt, 16'd0);
    chk("clr_fwd_cnt", fwd_cnt, 16'd0);

    // Persistent hazard: stall alternates 1,0,1,0.
    set_id(1'b1, 5'd10, 5'd0, 2'b01);
    set_ex(1'b1, 1'b1, 1'b1, 5'd10);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bub_stall_%0d", i), stall, (i % 2 == 0) ? 1'b1 : 1'b0);
      step();
      chk($sformatf("bub_sel_%0d", i), fwd_sel,
          (i % 2 == 0) ? 4'b0000 : 4'b0010);
    end
    chk("bub_stall_cnt", stall_cnt, 16'd2);
    chk("bub_fwd_cnt", fwd_cnt, 16'd2);
    chk("bub_stall_cnt2", stall_cnt2, 2'd2);

    // Four more stalls: six in total, narrow counter pinned at 3.
    for (int i = 0; i < 8; i++) step();
    chk("sat_stall_cnt", stall_cnt, 16'd6);
    chk("sat_stall_cnt2", stall_cnt2, 2'd3);

    // Clear wins over an increment in the same cycle.
    cnt_clr = 1'b1;
    #1;
    chk("clrstall_stall", stall, 1'b1);
    step();
    cnt_clr = 1'b0;
    chk("clrstall_cnt", stall_cnt, 16'd0);
    chk("clrstall_cnt2", stall_cnt2, 2'd0);

    // Reset while in BUBBLE; hazard kept on throughout.
    rst_n = 1'b0;
    #1;
    chk("rstbub_stall", stall, 1'b0);
    step();
    chk("rstbub_sel", fwd_sel, 4'b0000);
    chk("rstbub_stall_cnt", stall_cnt, 16'd0);
    chk("rstbub_fwd_cnt", fwd_cnt, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("rstbub_run_stall", stall, 1'b1);
    step();
    chk("rstbub_run_cnt", stall_cnt, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
